hack_cpu: RTL and testbench
===========================

HACK_CPU -- requirements
Module: hack_cpu

Interface
REQ-001 Parameter RESET_PC, default 15'h0000, is the PC value loaded by reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous active-high reset.
REQ-005 Port: imem_req  out  1  instruction fetch request.
REQ-006 Port: imem_addr  out  15  fetch address, equal to pc.
REQ-007 Port: imem_ack  in  1  fetch data valid this cycle.
REQ-008 Port: imem_rdata  in  16  instruction word.
REQ-009 Port: dmem_re  out  1  data read request.
REQ-010 Port: dmem_we  out  1  data write request.
REQ-011 Port: dmem_addr  out  15  A[14:0], sampled before the instruction updates A.
REQ-012 Port: dmem_wdata  out  16  ALU result.
REQ-013 Port: dmem_ack  in  1  read data valid or write accepted this cycle.
REQ-014 Port: dmem_rdata  in  16  M operand.
REQ-015 Port: pc_out, a_out, d_out  out  15/16/16  architectural state, for debug.
REQ-016 Port: retired  out  1  one-cycle pulse on the final cycle of each instruction.

Function
REQ-017 Decode: instr[15]=0 is an A-instruction (A<=instr). instr[15]=1 is a C-instruction with fields a=[12], zx,nx,zy,ny,f,no=[11:6], dest A,D,M=[5:3], jump lt,eq,gt=[2:0]; bits [14:13] are ignored.
REQ-018 The existing alu SHALL be instantiated with x=D, y=(a ? M : A), and the control bits taken directly from instr[11:6].
REQ-019 The FSM SHALL have four states: FETCH, READM, EXEC, WRITEM.
REQ-020 FETCH: hold imem_req=1 with a stable imem_addr until imem_ack. On ack, latch instr and go to READM if (C-instruction and a=1), otherwise to EXEC.
REQ-021 READM: hold dmem_re=1 until dmem_ack. On ack, latch M and go to EXEC.
REQ-022 EXEC, single cycle: commit A/D per dest using old A/D/M values, update pc, latch the ALU output into the write buffer. Go to WRITEM if dest M=1, otherwise go to FETCH with retired=1.
REQ-023 WRITEM: hold dmem_we=1, dmem_addr=old A, and dmem_wdata until dmem_ack. On ack, pulse retired=1 and go to FETCH.
REQ-024 Jump is taken when (lt&ng)|(eq&zr)|(gt&~ng&~zr); a taken jump loads pc<=old A[14:0].
REQ-025 When no jump is taken, pc<=pc+1, wrapping 15'h7FFF to 15'h0000.
REQ-026 Request strobes SHALL be mutually exclusive: at most one of imem_req, dmem_re, dmem_we is high in any cycle.
REQ-027 An ack arriving while no request is pending SHALL be ignored.
REQ-028 Minimum latency with zero-wait acks: 2 cycles (A, or C with a=0 and no M write), 3 cycles (M read or M write only), 4 cycles (read-modify-write).
REQ-029 A simultaneous A write and M write SHALL use the pre-update A as dmem_addr.

Reset
REQ-030 While reset=1 at a clock edge: pc<=RESET_PC, A<=0, D<=0, instr<=0, state<=FETCH.
REQ-031 All request strobes and retired SHALL be 0 in the cycle following a reset edge.
REQ-032 Reset arriving mid-transaction SHALL abandon that transaction: no partial A/D/pc commit, and the strobe drops the next cycle.
REQ-033 imem_req SHALL assert in the first cycle after reset deasserts.

Structure
REQ-034 A shared package hack_defs SHALL hold instruction field bit positions, the state encoding, and the jump-bit names.
REQ-035 The only sub-module is the existing alu. The A, D, and pc registers and the FSM SHALL be local to hack_cpu.

Verification
REQ-036 Reset, then 0x0005 with zero-wait ack -> A=5, pc=1, retired in cycle 2.
REQ-037 0x0005 then 0xEDD0 (D=A+1) -> D=0x0006, A unchanged, pc=2, no dmem strobes.
REQ-038 A=100, D=7, 0xE308 (M=D), dmem_ack delayed 3 cycles -> dmem_we held 4 cycles with addr=100, wdata=7, then retired.
REQ-039 A=100, M=41, 0xFDC8 (M=M+1) -> READM then WRITEM, wdata=42, 4 cycles total at zero wait.
REQ-040 A=0x0020, 0xEA87 (0;JMP) -> pc=0x0020. With D=0xFFFF, 0xE301 (D;JGT) -> not taken, pc increments.
REQ-041 Reset asserted during WRITEM -> dmem_we=0 next cycle, pc=RESET_PC, A=D=0, then fetch restarts.

Source files
------------

// File: rtl/hack_defs.sv
// Shared definitions for the Hack CPU: word/address widths, instruction field
// bit positions, jump-bit names, FSM state encoding and the jump predicate.
package hack_defs;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned PC_W   = 15;

    // Instruction field positions
    localparam int unsigned BIT_CI     = 15;  // 1 = C-instruction
    localparam int unsigned BIT_A      = 12;  // y operand select: 1 = M
    localparam int unsigned BIT_ZX     = 11;
    localparam int unsigned BIT_NX     = 10;
    localparam int unsigned BIT_ZY     = 9;
    localparam int unsigned BIT_NY     = 8;
    localparam int unsigned BIT_F      = 7;
    localparam int unsigned BIT_NO     = 6;
    localparam int unsigned BIT_DEST_A = 5;
    localparam int unsigned BIT_DEST_D = 4;
    localparam int unsigned BIT_DEST_M = 3;

    // Jump bits
    localparam int unsigned BIT_JLT = 2;
    localparam int unsigned BIT_JEQ = 1;
    localparam int unsigned BIT_JGT = 0;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_READM  = 2'd1,
        S_EXEC   = 2'd2,
        S_WRITEM = 2'd3
    } state_t;

    // Jump condition from the three jump bits and the ALU flags
    function automatic logic jump_taken(input logic [2:0] jmp, input logic ng, input logic zr);
        return (jmp[BIT_JLT] & ng) | (jmp[BIT_JEQ] & zr) | (jmp[BIT_JGT] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_if.sv
// Memory-side bus of the Hack CPU: instruction fetch and data read/write
// request/ack handshakes.
//   master (CPU):    drives imem_req/imem_addr, dmem_re/dmem_we/dmem_addr/dmem_wdata
//   slave (memory):  drives imem_ack/imem_rdata, dmem_ack/dmem_rdata
interface hack_cpu_if;
    import hack_defs::*;

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [WORD_W-1:0] imem_rdata;
    logic              dmem_re;
    logic              dmem_we;
    logic [PC_W-1:0]   dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [WORD_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_re, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_re, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/alu.sv
// Hack ALU (combinational).
//   x, y            : 16-bit operands
//   zx,nx,zy,ny,f,no: control bits (zero/negate x, zero/negate y, add-or-and, negate out)
//   out, zr, ng     : result, result==0, result<0
module alu
    import hack_defs::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic              zx,
    input  logic              nx,
    input  logic              zy,
    input  logic              ny,
    input  logic              f,
    input  logic              no,
    output logic [WORD_W-1:0] out,
    output logic              zr,
    output logic              ng
);
    logic [WORD_W-1:0] xz, xn, yz, yn, r;

    // Operand conditioning, function select, output negate
    always_comb begin
        xz  = zx ? '0 : x;
        xn  = nx ? ~xz : xz;
        yz  = zy ? '0 : y;
        yn  = ny ? ~yz : yz;
        r   = f ? (xn + yn) : (xn & yn);
        out = no ? ~r : r;
    end

    assign zr = (out == '0);
    assign ng = out[WORD_W-1];

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core with request/ack instruction and data memory ports.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : hack_cpu_if master (imem fetch, dmem read/write)
//   pc_out, a_out, d_out : architectural state for debug
//   retired    : pulse on the final cycle of each instruction
module hack_cpu
    import hack_defs::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 15'h0000
) (
    input  logic              clk,
    input  logic              reset,
    hack_cpu_if.master        bus,
    output logic [PC_W-1:0]   pc_out,
    output logic [WORD_W-1:0] a_out,
    output logic [WORD_W-1:0] d_out,
    output logic              retired
);
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, addr_q, addr_d;
    logic [WORD_W-1:0] a_q, a_d, d_q, d_d, instr_q, instr_d, m_q, m_d, wbuf_q, wbuf_d;
    logic              imem_req_q, imem_req_d, dmem_re_q, dmem_re_d, dmem_we_q, dmem_we_d;
    logic              retired_c;
    logic [WORD_W-1:0] alu_y, alu_out;
    logic              alu_zr, alu_ng;

    assign alu_y = instr_q[BIT_A] ? m_q : a_q;

    alu u_alu (
        .x   (d_q),
        .y   (alu_y),
        .zx  (instr_q[BIT_ZX]),
        .nx  (instr_q[BIT_NX]),
        .zy  (instr_q[BIT_ZY]),
        .ny  (instr_q[BIT_NY]),
        .f   (instr_q[BIT_F]),
        .no  (instr_q[BIT_NO]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        d_d       = d_q;
        instr_d   = instr_q;
        m_d       = m_q;
        wbuf_d    = wbuf_q;
        retired_c = 1'b0;
        // Track A until EXEC so WRITEM still addresses the pre-update A
        addr_d    = (state_q == S_WRITEM) ? addr_q : a_q[PC_W-1:0];

        case (state_q)
            S_FETCH: begin
                if (imem_req_q && bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = (bus.imem_rdata[BIT_CI] && bus.imem_rdata[BIT_A]) ? S_READM : S_EXEC;
                end
            end
            S_READM: begin
                if (dmem_re_q && bus.dmem_ack) begin
                    m_d     = bus.dmem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!instr_q[BIT_CI]) begin
                    a_d       = instr_q;
                    pc_d      = pc_q + PC_W'(1);
                    state_d   = S_FETCH;
                    retired_c = 1'b1;
                end else begin
                    if (instr_q[BIT_DEST_A]) a_d = alu_out;
                    if (instr_q[BIT_DEST_D]) d_d = alu_out;
                    wbuf_d = alu_out;
                    pc_d   = jump_taken(instr_q[BIT_JLT:BIT_JGT], alu_ng, alu_zr)
                             ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
                    if (instr_q[BIT_DEST_M]) begin
                        state_d = S_WRITEM;
                    end else begin
                        state_d   = S_FETCH;
                        retired_c = 1'b1;
                    end
                end
            end
            S_WRITEM: begin
                if (dmem_we_q && bus.dmem_ack) begin
                    state_d   = S_FETCH;
                    retired_c = 1'b1;
                end
            end
            default: state_d = S_FETCH;
        endcase

        // Strobes follow the state being entered, so at most one is ever high
        imem_req_d = (state_d == S_FETCH);
        dmem_re_d  = (state_d == S_READM);
        dmem_we_d  = (state_d == S_WRITEM);
    end

    // State and architectural registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            a_q        <= '0;
            d_q        <= '0;
            instr_q    <= '0;
            m_q        <= '0;
            wbuf_q     <= '0;
            addr_q     <= '0;
            imem_req_q <= 1'b0;
            dmem_re_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            a_q        <= a_d;
            d_q        <= d_d;
            instr_q    <= instr_d;
            m_q        <= m_d;
            wbuf_q     <= wbuf_d;
            addr_q     <= addr_d;
            imem_req_q <= imem_req_d;
            dmem_re_q  <= dmem_re_d;
            dmem_we_q  <= dmem_we_d;
        end
    end

    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_re    = dmem_re_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wbuf_q;

    assign pc_out  = pc_q;
    assign a_out   = a_q;
    assign d_out   = d_q;
    // Completion in a reset cycle is abandoned, so it never reports
    assign retired = retired_c & ~reset;

endmodule

// File: tb/tb_hack_cpu.sv
// Self-checking bench for hack_cpu: memory responder with configurable ack
// delays and stray acks, plus an instruction-level reference model.
module tb_hack_cpu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [14:0] pc_out;
    logic [15:0] a_out, d_out;
    logic        retired;

    hack_cpu_if bus();

    hack_cpu #(.RESET_PC(15'h0000)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.master),
        .pc_out  (pc_out),
        .a_out   (a_out),
        .d_out   (d_out),
        .retired (retired)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] COMP_CODES [18] = '{
        6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
        6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
        6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101
    };

    logic [15:0] imem [32768];
    logic [15:0] dmem [32768];
    logic [15:0] ref_dmem [32768];

    // Reference architectural state
    logic [14:0] m_pc;
    logic [15:0] m_a, m_d;

    int n_assert = 0;
    int n_fail   = 0;
    int age = 0, lat = 0, last_lat = 0, we_cycles = 0;
    int imem_dly = 0, dmem_dly = 0;
    logic strays = 1'b0, rand_dly = 1'b0, lat_chk = 1'b1;
    logic chk_pending = 1'b0, wr_seen = 1'b0, dmem_seen = 1'b0, retired_now = 1'b0;
    logic [14:0] wr_addr = '0;
    logic [15:0] wr_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hack computation table by mnemonic meaning
    function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] x, input logic [15:0] y);
        case (c)
            6'b101010: return 16'd0;
            6'b111111: return 16'd1;
            6'b111010: return 16'hFFFF;
            6'b001100: return x;
            6'b110000: return y;
            6'b001101: return ~x;
            6'b110001: return ~y;
            6'b001111: return 16'd0 - x;
            6'b110011: return 16'd0 - y;
            6'b011111: return x + 16'd1;
            6'b110111: return y + 16'd1;
            6'b001110: return x - 16'd1;
            6'b110010: return y - 16'd1;
            6'b000010: return x + y;
            6'b010011: return x - y;
            6'b000111: return y - x;
            6'b000000: return x & y;
            6'b010101: return x | y;
            default:   return 16'hxxxx;
        endcase
    endfunction

    task automatic model_retire();
        logic [15:0] ins, y, r, old_a;
        int exp_lat;
        logic taken;
        ins = imem[m_pc];
        last_lat = lat;
        lat = 0;
        if (!ins[15]) begin
            exp_lat = 2;
            check("a_instr_no_write", 32'(wr_seen), 32'd0);
            m_a  = ins;
            m_pc = m_pc + 15'd1;
        end else begin
            old_a = m_a;
            y = ins[12] ? ref_dmem[old_a[14:0]] : old_a;
            r = ref_alu(ins[11:6], m_d, y);
            exp_lat = 2 + int'(ins[12]) + int'(ins[3]);
            if (ins[3]) begin
                check("mwrite_seen", 32'(wr_seen), 32'd1);
                check("mwrite_addr", 32'(wr_addr), 32'(old_a[14:0]));
                check("mwrite_data", 32'(wr_data), 32'(r));
                ref_dmem[old_a[14:0]] = r;
            end else begin
                check("no_mwrite", 32'(wr_seen), 32'd0);
            end
            if (ins[5]) m_a = r;
            if (ins[4]) m_d = r;
            taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'd0) || (ins[0] && $signed(r) > 0);
            m_pc = taken ? old_a[14:0] : m_pc + 15'd1;
        end
        wr_seen = 1'b0;
        if (lat_chk) check("latency", 32'(last_lat), 32'(exp_lat));
        if (rand_dly) begin
            imem_dly = $urandom_range(0, 3);
            dmem_dly = $urandom_range(0, 3);
        end
        chk_pending = 1'b1;
    endtask

    // One clock: deferred state check, bus checks, memory response, retire tracking
    task automatic tick();
        int n_strobes;
        @(negedge clk);
        if (chk_pending) begin
            chk_pending = 1'b0;
            check("pc", 32'(pc_out), 32'(m_pc));
            check("a", 32'(a_out), 32'(m_a));
            check("d", 32'(d_out), 32'(m_d));
        end
        n_strobes = int'(bus.imem_req) + int'(bus.dmem_re) + int'(bus.dmem_we);
        check("strobe_onehot", 32'(n_strobes > 1), 32'd0);
        if (bus.dmem_re || bus.dmem_we) dmem_seen = 1'b1;
        if (bus.dmem_we) we_cycles++;

        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        if (!reset) begin
            if (bus.imem_req) begin
                if (age >= imem_dly) begin
                    bus.imem_ack   = 1'b1;
                    bus.imem_rdata = imem[bus.imem_addr];
                    age = 0;
                end else age++;
            end else if (strays && $urandom_range(0, 3) == 0) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = 16'($urandom);
            end
            if (bus.dmem_re || bus.dmem_we) begin
                if (age >= dmem_dly) begin
                    bus.dmem_ack = 1'b1;
                    if (bus.dmem_re) begin
                        bus.dmem_rdata = dmem[bus.dmem_addr];
                    end else begin
                        dmem[bus.dmem_addr] = bus.dmem_wdata;
                        wr_seen = 1'b1;
                        wr_addr = bus.dmem_addr;
                        wr_data = bus.dmem_wdata;
                    end
                    age = 0;
                end else age++;
            end else if (strays && $urandom_range(0, 3) == 0) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = 16'($urandom);
            end
        end
        #1;
        lat++;
        retired_now = retired;
        if (retired) model_retire();
    endtask

    task automatic run_instrs(input int n);
        int got;
        int budget;
        got = 0;
        budget = n * 60;
        while (got < n && budget > 0) begin
            tick();
            budget--;
            if (retired_now) got++;
        end
        check("retire_budget", 32'(got), 32'(n));
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_dmem_re", 32'(bus.dmem_re), 32'd0);
        check("rst_dmem_we", 32'(bus.dmem_we), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        check("rst_pc", 32'(pc_out), 32'h0000);
        check("rst_a", 32'(a_out), 32'd0);
        check("rst_d", 32'(d_out), 32'd0);
        m_pc = 15'h0000;
        m_a  = 16'd0;
        m_d  = 16'd0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("req_after_reset", 32'(bus.imem_req), 32'd1);
        age = 0;
        lat = 0;
        chk_pending = 1'b0;
        wr_seen = 1'b0;
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.imem_ack   = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.imem_rdata = 16'd0;
        bus.dmem_rdata = 16'd0;
        for (int i = 0; i < 32768; i++) begin
            imem[i]     = 16'($urandom);
            dmem[i]     = 16'($urandom);
            ref_dmem[i] = dmem[i];
        end
        imem[0]     = 16'h0005;
        imem[1]     = 16'hEDD0;
        imem[2]     = 16'h0007;
        imem[3]     = 16'hEC10;
        imem[4]     = 16'h0064;
        imem[5]     = 16'hE308;
        imem[6]     = 16'hFDC8;
        imem[7]     = 16'h0020;
        imem[8]     = 16'hEA87;
        imem[16'h20] = 16'hEE90;
        imem[16'h21] = 16'hE301;
        imem[16'h22] = 16'hE308;

        do_reset();

        // @A 5 retires on its second cycle
        run_instrs(1);
        settle();
        check("r036_retire_cycle", 32'(last_lat), 32'd2);
        check("r036_a", 32'(a_out), 32'h0005);
        check("r036_pc", 32'(pc_out), 32'h0001);

        // D=A+1 touches no data memory
        dmem_seen = 1'b0;
        run_instrs(1);
        settle();
        check("r037_d", 32'(d_out), 32'h0006);
        check("r037_a", 32'(a_out), 32'h0005);
        check("r037_pc", 32'(pc_out), 32'h0002);
        check("r037_no_dmem", 32'(dmem_seen), 32'd0);

        // M=D at A=100 with a three-cycle ack delay
        run_instrs(3);
        lat_chk   = 1'b0;
        dmem_dly  = 3;
        we_cycles = 0;
        run_instrs(1);
        check("r038_we_cycles", 32'(we_cycles), 32'd4);
        check("r038_addr", 32'(wr_addr), 32'd100);
        check("r038_wdata", 32'(wr_data), 32'd7);
        dmem_dly = 0;
        lat_chk  = 1'b1;

        // M=M+1 read-modify-write
        dmem[100]     = 16'd41;
        ref_dmem[100] = 16'd41;
        run_instrs(1);
        check("r039_latency", 32'(last_lat), 32'd4);
        check("r039_addr", 32'(wr_addr), 32'd100);
        check("r039_wdata", 32'(wr_data), 32'd42);

        // Unconditional jump, then a JGT on a negative D
        run_instrs(2);
        settle();
        check("r040_jmp_pc", 32'(pc_out), 32'h0020);
        run_instrs(2);
        settle();
        check("r040_jgt_pc", 32'(pc_out), 32'h0022);
        check("r040_d", 32'(d_out), 32'hFFFF);

        // Reset while WRITEM is waiting for its ack
        dmem_dly = 50;
        for (int k = 0; k < 20 && !bus.dmem_we; k++) tick();
        check("r041_in_writem", 32'(bus.dmem_we), 32'd1);
        reset = 1'b1;
        tick();
        check("r041_we_drop", 32'(bus.dmem_we), 32'd0);
        check("r041_pc", 32'(pc_out), 32'h0000);
        check("r041_a", 32'(a_out), 32'd0);
        check("r041_d", 32'(d_out), 32'd0);
        check("r041_retired", 32'(retired), 32'd0);
        do_reset();
        dmem_dly = 0;
        run_instrs(1);
        settle();
        check("r041_restart_a", 32'(a_out), 32'h0005);

        // Random programs: zero-wait with stray acks, then random delays
        for (int i = 0; i < 32768; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                imem[i] = {1'b0, 15'($urandom)};
            end else begin
                imem[i] = {1'b1, 2'($urandom), 1'($urandom),
                           COMP_CODES[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
            end
            dmem[i]     = 16'($urandom);
            ref_dmem[i] = dmem[i];
        end
        strays = 1'b1;
        do_reset();
        lat_chk = 1'b1;
        run_instrs(300);
        lat_chk  = 1'b0;
        rand_dly = 1'b1;
        run_instrs(300);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
